// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: applies one single-bit rotate/shift per clock
// through a one-bit stage until the requested count is used up, then holds
// the result on a valid/ready output until the consumer takes it.

// One-bit shifting stage. With Shift low the operand passes through unchanged.
module shift0 (
  input  logic [15:0] In,
  input  logic [1:0]  Op,
  input  logic        Shift,
  output logic [15:0] Out
);

  // Select the single-bit step for the requested opcode
  always_comb begin
    Out = In;
    if (Shift) begin
      case (Op)
        2'b00: Out = {In[14:0], In[15]};
        2'b01: Out = {In[14:0], 1'b0};
        2'b10: Out = {In[0], In[15:1]};
        2'b11: Out = {1'b0, In[15:1]};
        default: Out = In;
      endcase
    end
  end

endmodule

module shift_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] In,
  input  logic [1:0]       Op,
  input  logic [CNT_W-1:0] Cnt,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Out,
  output logic             Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] remain_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] shifted_d;

  // The one-bit stage always works on the captured operand and opcode
  shift0 u_shift0 (
    .In    (data_q),
    .Op    (op_q),
    .Shift (1'b1),
    .Out   (shifted_d)
  );

  // Sequencer: capture a request, step once per clock, hold until popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      op_q     <= '0;
      remain_q <= '0;
      out_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (InValid) begin
            data_q   <= In;
            op_q     <= Op;
            remain_q <= Cnt;
            if (Cnt == '0) begin
              out_q   <= In;
              state_q <= HOLD;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q   <= shifted_d;
          remain_q <= remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            out_q   <= shifted_d;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (OutReady) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign InReady  = (state_q == IDLE) & ~rst;
  assign OutValid = (state_q == HOLD);
  assign Busy     = (state_q != IDLE);
  assign Out      = out_q;

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: a table of operand/opcode/count vectors with their
// results, a scoreboard queue holding the expected result and latency of each
// accepted request, and hand-written sequences for backpressure and reset abort.
module tb_shift_seq;

  typedef struct {
    logic [15:0] in;
    logic [1:0]  op;
    logic [3:0]  cnt;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] exp;
    int          lat;
  } sb_t;

  logic        clk;
  logic        rst;
  logic        InValid;
  logic        InReady;
  logic [15:0] In;
  logic [1:0]  Op;
  logic [3:0]  Cnt;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] Out;
  logic        Busy;

  int   checks;
  int   failures;
  sb_t  sbq[$];
  vec_t vecs[12];

  shift_seq #(.WIDTH(16), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .InValid  (InValid),
    .InReady  (InReady),
    .In       (In),
    .Op       (Op),
    .Cnt      (Cnt),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Out      (Out),
    .Busy     (Busy)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive a request, wait (bounded) for acceptance, and record what should come back.
  // Called and returns at #1 after a rising edge.
  task automatic applyStimulus(input logic [15:0] in, input logic [1:0] op,
                               input logic [3:0] cnt, input logic [15:0] exp);
    int waitCnt;
    waitCnt = 0;
    InValid = 1'b1;
    In      = in;
    Op      = op;
    Cnt     = cnt;
    while (!InReady && waitCnt < 40) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    if (!InReady) begin
      checkValue("accept timeout", 32'd0, 32'd1);
      InValid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      InValid = 1'b0;
      sbq.push_back('{exp, int'(cnt)});
    end
  endtask

  // Wait (bounded) for a result, compare against the scoreboard, then pop it
  task automatic checkOutput(input string name);
    int  n;
    sb_t e;
    n = 0;
    while (!OutValid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sbq.size() == 0) begin
      checkValue({name, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      checkValue({name, " latency"}, n, e.lat);
      checkValue({name, " data"}, {16'h0, Out}, {16'h0, e.exp});
    end
    if (OutValid) begin
      OutReady = 1'b1;
      @(posedge clk);
      #1;
      OutReady = 1'b0;
      checkValue({name, " idle after pop"}, {30'd0, Busy, InReady}, 32'd1);
    end
  endtask

  initial begin
    int  n;
    bit  seen;
    sb_t e;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    InValid  = 1'b0;
    OutReady = 1'b0;
    In       = '0;
    Op       = '0;
    Cnt      = '0;

    vecs[0]  = '{16'h8001, 2'b00, 4'd1,  16'h0003};
    vecs[1]  = '{16'h1234, 2'b10, 4'd4,  16'h4123};
    vecs[2]  = '{16'h8001, 2'b11, 4'd15, 16'h0001};
    vecs[3]  = '{16'h1234, 2'b01, 4'd4,  16'h2340};
    vecs[4]  = '{16'hBEEF, 2'b00, 4'd0,  16'hBEEF};
    vecs[5]  = '{16'hBEEF, 2'b11, 4'd0,  16'hBEEF};
    vecs[6]  = '{16'h0001, 2'b00, 4'd15, 16'h8000};
    vecs[7]  = '{16'hFFFF, 2'b01, 4'd15, 16'h8000};
    vecs[8]  = '{16'hFFFF, 2'b11, 4'd15, 16'h0001};
    vecs[9]  = '{16'h8000, 2'b10, 4'd15, 16'h0001};
    vecs[10] = '{16'h12AB, 2'b00, 4'd8,  16'hAB12};
    vecs[11] = '{16'h00F0, 2'b11, 4'd4,  16'h000F};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset Out", {16'h0, Out}, 32'h0);
    checkValue("reset OutValid", {31'd0, OutValid}, 32'd0);
    checkValue("reset Busy", {31'd0, Busy}, 32'd0);
    checkValue("reset InReady", {31'd0, InReady}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkValue("InReady after reset", {31'd0, InReady}, 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].in, vecs[i].op, vecs[i].cnt, vecs[i].exp);
      checkOutput($sformatf("vec%0d", i));
    end

    // Backpressure: result held while OutReady low, new request waits
    applyStimulus(16'h1234, 2'b10, 4'd4, 16'h4123);
    n = 0;
    while (!OutValid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = sbq.pop_front();
    checkValue("bp latency", n, e.lat);
    InValid = 1'b1;
    In      = 16'hFFFF;
    Op      = 2'b11;
    Cnt     = 4'd1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkValue($sformatf("bp hold data %0d", k), {16'h0, Out}, {16'h0, e.exp});
      checkValue($sformatf("bp hold valid %0d", k), {31'd0, OutValid}, 32'd1);
      checkValue($sformatf("bp InReady low %0d", k), {31'd0, InReady}, 32'd0);
    end
    OutReady = 1'b1;
    @(posedge clk);
    #1;
    OutReady = 1'b0;
    checkValue("bp not accepted at pop", {30'd0, Busy, InReady}, 32'd1);
    @(posedge clk);
    #1;
    InValid = 1'b0;
    sbq.push_back('{16'h7FFF, 1});
    checkValue("bp accepted after pop", {31'd0, Busy}, 32'd1);
    checkOutput("bp new");

    // Reset in the middle of a long operation
    applyStimulus(16'h0F0F, 2'b00, 4'd8, 16'hF0F0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    sbq.delete();
    checkValue("abort Out", {16'h0, Out}, 32'h0);
    checkValue("abort OutValid", {31'd0, OutValid}, 32'd0);
    checkValue("abort Busy", {31'd0, Busy}, 32'd0);
    checkValue("abort InReady", {31'd0, InReady}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkValue("abort InReady after release", {31'd0, InReady}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (OutValid) seen = 1'b1;
    end
    checkValue("abort no result", {31'd0, seen}, 32'd0);
    applyStimulus(16'h0F0F, 2'b00, 4'd4, 16'hF0F0);
    checkOutput("after abort");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
